spi_mem_arbiter: RTL and testbench

Sequences and shares the single external SPI SRAM port (23LC512-class, 16-bit address, SPI mode 0) between the Hack CPU's instruction-fetch requester and its data (A/M) requester. It sits inside `cpu_top`, between the CPU core and the `csb_o`/`sclk_o`/`mo_o`/`mi_i` pins. It arbitrates pending requests, serialises one 40-bit read or write transaction at a time, and returns a one-cycle completion pulse to the granted requester. It honours an external halt by not starting new transactions.

---
 rtl/hack_pkg.sv | 27 ++
 rtl/spi_frame_shifter.sv | 46 ++++
 rtl/spi_mem_arbiter.sv | 113 +++++++++++
 tb/tb_spi_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared SPI SRAM constants, arbiter state encoding and frame builder for the
// Hack CPU memory path.
package hack_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         SPI_FRAME_BITS = 40;
  localparam int         SPI_BIT_CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } arb_state_t;

  // Word address becomes a byte address; read frames carry zeros in the data field.
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(
    input logic        we,
    input logic [14:0] addr,
    input logic [15:0] wdata
  );
    return {(we ? SPI_CMD_WRITE : SPI_CMD_READ), addr, 1'b0, (we ? wdata : 16'h0000)};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// 40-bit MSB-first SPI mode-0 frame shifter: two clocks per bit, MISO captured
// at the end of the SCLK-high phase.
module spi_frame_shifter
  import hack_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      load,
  input  logic [SPI_FRAME_BITS-1:0] frame,
  input  logic                      shift_en,
  input  logic                      mi,
  output logic                      mo,
  output logic                      phase,
  output logic                      last_bit,
  output logic [15:0]               rx_data
);

  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt;

  // NOTE: the shift and receive registers are datapath, but resetting them keeps
  // the MOSI pin and read data X-free out of reset at negligible cost here.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      shreg   <= '0;
      rx_data <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= frame;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      phase <= ~phase;
      if (phase) begin
        shreg   <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
        rx_data <= {rx_data[14:0], mi};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign mo       = shreg[SPI_FRAME_BITS-1];
  assign last_bit = phase && (bit_cnt == SPI_BIT_CNT_W'(SPI_FRAME_BITS - 1));

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI SRAM between the Hack fetch and data requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-first priority.
module spi_mem_arbiter
  import hack_pkg::*;
#(
  parameter int CLK_PER_BIT = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        halt_i,
  input  logic        if_req_i,
  input  logic [14:0] if_addr_i,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [14:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [15:0] rdata_o,
  output logic        busy_o,
  output logic        csb_o,
  output logic        sclk_o,
  output logic        mo_o,
  input  logic        mi_i
);

  if (CLK_PER_BIT != 2) begin : g_bad_clk_per_bit
    $error("spi_mem_arbiter supports only CLK_PER_BIT = 2");
  end

  arb_state_t                state, state_nxt;
  logic                      grant, pick_data;
  logic                      gnt_data, we_q;
  logic                      sh_mo, sh_phase, sh_last;
  logic [15:0]               sh_rx;
  logic [SPI_FRAME_BITS-1:0] frame;

  assign grant = (state == IDLE) && !halt_i && (if_req_i || d_req_i);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prio_data;

  always_ff @(posedge clk) begin
    if (!resetb)    prio_data <= 1'b1;
    else if (grant) prio_data <= !pick_data;
  end

  assign pick_data = d_req_i && (!if_req_i || prio_data);
`else
  assign pick_data = d_req_i;
`endif

  assign frame = pick_data ? build_frame(d_we_i, d_addr_i, d_wdata_i)
                           : build_frame(1'b0, if_addr_i, 16'h0000);

  spi_frame_shifter u_shifter (
    .clk      (clk),
    .resetb   (resetb),
    .load     (grant),
    .frame    (frame),
    .shift_en (state == SHIFT),
    .mi       (mi_i),
    .mo       (sh_mo),
    .phase    (sh_phase),
    .last_bit (sh_last),
    .rx_data  (sh_rx)
  );

  // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = SETUP;
      SETUP:   state_nxt = SHIFT;
      SHIFT:   if (sh_last) state_nxt = HOLD;
      HOLD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state    <= IDLE;
      gnt_data <= 1'b0;
      we_q     <= 1'b0;
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      rdata_o  <= '0;
    end else begin
      state    <= state_nxt;
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      if (grant) begin
        gnt_data <= pick_data;
        we_q     <= pick_data && d_we_i;
      end
      // Acks and read data become visible in the DONE cycle.
      if (state == HOLD) begin
        if_ack_o <= !gnt_data;
        d_ack_o  <= gnt_data;
        if (!we_q) rdata_o <= sh_rx;
      end
    end
  end

  assign csb_o  = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign sclk_o = (state == SHIFT) && sh_phase;
  assign mo_o   = ((state == SETUP) || (state == SHIFT)) ? sh_mo : 1'b0;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter with a behavioural 23LC512-style SPI SRAM.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        halt_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [14:0] if_addr_i = '0;
  logic        if_ack_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [14:0] d_addr_i = '0;
  logic [15:0] d_wdata_i = '0;
  logic        d_ack_o;
  logic [15:0] rdata_o;
  logic        busy_o;
  logic        csb_o;
  logic        sclk_o;
  logic        mo_o;
  logic        mi_i = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.CLK_PER_BIT(2)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .halt_i    (halt_i),
    .if_req_i  (if_req_i),
    .if_addr_i (if_addr_i),
    .if_ack_o  (if_ack_o),
    .d_req_i   (d_req_i),
    .d_we_i    (d_we_i),
    .d_addr_i  (d_addr_i),
    .d_wdata_i (d_wdata_i),
    .d_ack_o   (d_ack_o),
    .rdata_o   (rdata_o),
    .busy_o    (busy_o),
    .csb_o     (csb_o),
    .sclk_o    (sclk_o),
    .mo_o      (mo_o),
    .mi_i      (mi_i)
  );

  // SPI SRAM model: samples MOSI on SCLK rise, presents read data bit by bit.
  logic [15:0] mem [logic [15:0]];
  logic [39:0] mdl_sr;
  logic [39:0] frame_cap = '0;
  logic [7:0]  mdl_cmd;
  logic [15:0] mdl_addr;
  logic [15:0] mdl_word;
  int          mdl_n = 0;

  always @(negedge csb_o) begin
    mdl_n = 0;
    mi_i  = 1'b0;
  end

  always @(posedge sclk_o) begin
    if (!csb_o) begin
      mdl_sr = {mdl_sr[38:0], mo_o};
      mdl_n++;
      if (mdl_n == 24) begin
        mdl_cmd  = mdl_sr[23:16];
        mdl_addr = mdl_sr[15:0];
        mdl_word = mem.exists(mdl_addr) ? mem[mdl_addr] : 16'h0000;
      end
      if (mdl_n >= 25 && mdl_n <= 40 && mdl_cmd == 8'h03) mi_i = mdl_word[40 - mdl_n];
      if (mdl_n == 40) begin
        frame_cap = mdl_sr;
        if (mdl_cmd == 8'h02) mem[mdl_addr] = mdl_sr[15:0];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction; inputs are scrambled after grant to show they are ignored.
  task automatic run_txn(input logic fetch, input logic we, input logic [14:0] addr,
                         input logic [15:0] wdata, output int lat, output logic other_ack);
    @(negedge clk);
    if (fetch) begin
      if_addr_i = addr;
      if_req_i  = 1'b1;
    end else begin
      d_we_i    = we;
      d_addr_i  = addr;
      d_wdata_i = wdata;
      d_req_i   = 1'b1;
    end
    lat = 0;
    other_ack = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        if_addr_i = ~addr;
        d_addr_i  = ~addr;
        d_wdata_i = ~wdata;
        d_we_i    = ~we;
      end
      if (fetch ? d_ack_o : if_ack_o) other_ack = 1'b1;
      if (fetch ? if_ack_o : d_ack_o) begin
        lat = c;
        break;
      end
    end
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
    @(posedge clk);
    #1;
    check("ack_single_cycle", {62'd0, if_ack_o, d_ack_o}, 64'd0);
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        pre_en;
    logic [15:0] pre;
    logic [39:0] exp_frame;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    logic        other;
    int          bad;
    int          last_ack;
    logic        who [4];
    logic        exp_who [4];

    vecs[0] = '{1'b1, 1'b0, 15'h1234, 16'h0000, 1'b1, 16'hBEEF, 40'h03_2468_0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 15'h0010, 16'hA5A5, 1'b0, 16'h0000, 40'h02_0020_A5A5, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 15'h0010, 16'h0000, 1'b0, 16'h0000, 40'h03_0020_0000, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b0, 15'h7FFF, 16'h0000, 1'b1, 16'h0001, 40'h03_FFFE_0000, 16'h0001};
    vecs[4] = '{1'b0, 1'b1, 15'h0000, 16'hFFFF, 1'b0, 16'h0000, 40'h02_0000_FFFF, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 15'h0000, 16'h1357, 1'b0, 16'h0000, 40'h03_0000_0000, 16'hFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_csb", csb_o, 1'b1);
    check("reset_sclk", sclk_o, 1'b0);
    check("reset_mo", mo_o, 1'b0);
    check("reset_acks", {if_ack_o, d_ack_o}, 2'b00);
    check("reset_rdata", rdata_o, 16'h0000);
    check("reset_busy", busy_o, 1'b0);
    @(negedge clk);
    resetb = 1'b1;

    // Single transactions
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_en) mem[{vecs[i].addr, 1'b0}] = vecs[i].pre;
      run_txn(vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, other);
      check("txn_latency", lat, 83);
      check("txn_other_ack", other, 1'b0);
      if (vecs[i].we) begin
        check("txn_frame_write", frame_cap, vecs[i].exp_frame);
        check("txn_mem_write", mem.exists({vecs[i].addr, 1'b0}) ? mem[{vecs[i].addr, 1'b0}] : 16'hDEAD,
              vecs[i].wdata);
      end else begin
        check("txn_frame_read_hdr", frame_cap[39:16], vecs[i].exp_frame[39:16]);
      end
      check("txn_rdata", rdata_o, vecs[i].exp_rdata);
      check("txn_csb_idle", csb_o, 1'b1);
    end

    // Both requesters held continuously
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_who = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_who = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    if_addr_i = 15'h0100;
    d_we_i    = 1'b0;
    d_addr_i  = 15'h0200;
    if_req_i  = 1'b1;
    d_req_i   = 1'b1;
    last_ack  = 0;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      who[k] = 1'bx;
      for (int c = 1; c <= 200; c++) begin
        @(posedge clk);
        #1;
        if (if_ack_o || d_ack_o) begin
          lat = c;
          who[k] = d_ack_o;
          break;
        end
      end
      check("both_grant_order", who[k], exp_who[k]);
      check("both_ack_spacing", lat, (k == 0) ? 83 : 84);
    end
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
    repeat (2) @(posedge clk);

    // Halt raised during SHIFT
    @(negedge clk);
    if_addr_i = 15'h0055;
    if_req_i  = 1'b1;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 30) begin
        halt_i    = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 15'h0066;
        d_req_i   = 1'b1;
      end
      if (if_ack_o) begin
        lat = c;
        break;
      end
    end
    if_req_i = 1'b0;
    check("halt_inflight_latency", lat, 83);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (busy_o || !csb_o || sclk_o || d_ack_o) bad++;
    end
    check("halt_no_grant", bad, 0);
    @(negedge clk);
    halt_i = 1'b0;
    @(posedge clk);
    #1;
    check("halt_release_grant", busy_o, 1'b1);
    lat = 0;
    for (int c = 2; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (d_ack_o) begin
        lat = c;
        break;
      end
    end
    d_req_i = 1'b0;
    check("halt_release_latency", lat, 83);
    repeat (2) @(posedge clk);

    // Reset pulsed at SHIFT bit 20
    @(negedge clk);
    d_we_i    = 1'b1;
    d_addr_i  = 15'h0040;
    d_wdata_i = 16'h1111;
    d_req_i   = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_in_shift", {csb_o, sclk_o}, 2'b00);
    resetb  = 1'b0;
    d_req_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_csb", csb_o, 1'b1);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_sclk", sclk_o, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (if_ack_o || d_ack_o || busy_o) bad++;
    end
    check("rst_mid_no_ack", bad, 0);
    check("rst_mid_no_write", mem.exists(16'h0080), 1'b0);
    run_txn(1'b0, 1'b1, 15'h0040, 16'h1111, lat, other);
    check("reissue_latency", lat, 83);
    check("reissue_mem", mem.exists(16'h0080) ? mem[16'h0080] : 16'hDEAD, 16'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
